// File: rtl/flip_select_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : flip_select_sequencer_if
// Summary   : Job, table-read, selector-control and flip-result signals of the
//             flip select sequencer. The sequencer uses the slave modport; the
//             surrounding environment uses the master modport.
// Revision  : 1.0 - initial release
// ============================================================================
interface flip_select_sequencer_if #(
  parameter int NSAT     = 3,
  parameter int VAR_BITS = 16
);
  localparam int NSAT_BITS = $clog2(NSAT);

  // clause job
  logic                     start_i;
  logic                     ready_o;
  logic [NSAT*VAR_BITS-1:0] lits_i;
  logic [NSAT-1:0]          lit_valid_i;

  // variable-clause table read
  logic                     var_rd_en_o;
  logic [VAR_BITS-1:0]      var_addr_o;

  // flip selector control
  logic [NSAT_BITS-1:0]     wr_en_o;
  logic [NSAT-1:0]          break_values_valid_o;
  logic [31:0]              random_o;
  logic [NSAT_BITS-1:0]     selected_i;

  // flip result handshake
  logic                     flip_valid_o;
  logic                     flip_ready_i;
  logic [VAR_BITS-1:0]      flip_var_o;
  logic [NSAT_BITS-1:0]     flip_idx_o;
  logic                     flip_none_o;

  modport slave (
    input  start_i, lits_i, lit_valid_i, selected_i, flip_ready_i,
    output ready_o, var_rd_en_o, var_addr_o, wr_en_o, break_values_valid_o,
           random_o, flip_valid_o, flip_var_o, flip_idx_o, flip_none_o
  );

  modport master (
    output start_i, lits_i, lit_valid_i, selected_i, flip_ready_i,
    input  ready_o, var_rd_en_o, var_addr_o, wr_en_o, break_values_valid_o,
           random_o, flip_valid_o, flip_var_o, flip_idx_o, flip_none_o
  );
endinterface
`default_nettype wire

// File: rtl/flip_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : flip_select_sequencer
// Summary  : Accepts one unsatisfied clause, streams its literals' variable
//            indices to the variable-clause table, steers the flip selector's
//            write-enable encoding, captures the selector's choice and returns
//            the variable to flip over a valid/ready handshake. Also owns the
//            32-bit Galois LFSR feeding the selector's random input.
// Revision : 1.0 - initial release
// ============================================================================
module flip_select_sequencer #(
  parameter int          NSAT     = 3,
  parameter int          VAR_BITS = 16,
  parameter logic [31:0] SEED     = 32'hACE1_2468
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  flip_select_sequencer_if.slave bus
);

  localparam int                   NSAT_BITS = $clog2(NSAT);
  localparam logic [NSAT_BITS-1:0] C_LAST    = NSAT_BITS'(NSAT - 1);
  localparam logic [31:0]          C_TAPS    = 32'h8020_0003;
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0]          C_SEED    = (SEED == 32'h0) ? 32'h1 : SEED;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_SELECT  = 3'd2,
    S_CAPTURE = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [NSAT_BITS-1:0] r_k;
  logic [VAR_BITS-1:0]  r_lits [NSAT];
  logic [NSAT-1:0]      r_mask;
  logic [31:0]          r_lfsr;
  logic [NSAT_BITS-1:0] r_wr_en;
  logic [VAR_BITS-1:0]  r_flip_var;
  logic [NSAT_BITS-1:0] r_flip_idx;
  logic                 r_flip_none;

  logic                 w_ready;
  logic                 w_rd_en;
  logic                 w_flip_valid;
  logic                 w_accept;
  logic [VAR_BITS-1:0]  w_rd_addr;
  logic [VAR_BITS-1:0]  w_cap_var;
  logic                 w_cap_hit;
  logic [31:0]          w_lfsr_next;

  assign w_accept    = (r_state == S_IDLE) && bus.start_i;
  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? C_TAPS : 32'h0);

  // State register; an asynchronous reset aborts any job in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus the state-derived strobes.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_rd_en      = 1'b0;
    w_flip_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.start_i) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_rd_en = 1'b1;
        if (r_k == C_LAST) begin
          w_state_next = S_SELECT;
        end
      end
      S_SELECT: begin
        w_state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_next = S_OUT;
      end
      S_OUT: begin
        w_flip_valid = 1'b1;
        if (bus.flip_ready_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Literal cursor: cleared on accept, walks one literal per FETCH cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_k <= '0;
    end else if (w_accept) begin
      r_k <= '0;
    end else if (r_state == S_FETCH) begin
      r_k <= r_k + NSAT_BITS'(1);
    end
  end

  // Job capture: literal indices and presence mask are held for the whole job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NSAT; i++) begin
        r_lits[i] <= '0;
      end
      r_mask <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NSAT; i++) begin
        r_lits[i] <= bus.lits_i[i*VAR_BITS +: VAR_BITS];
      end
      r_mask <= bus.lit_valid_i;
    end
  end

  // LFSR steps once per accepted job so the selector sees one value per job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= C_SEED;
    end else if (w_accept) begin
      r_lfsr <= w_lfsr_next;
    end
  end

  // Table read address: the current literal while fetching, zero otherwise.
  always_comb begin
    w_rd_addr = '0;
    for (int i = 0; i < NSAT; i++) begin
      if ((r_state == S_FETCH) && (r_k == NSAT_BITS'(i))) begin
        w_rd_addr = r_lits[i];
      end
    end
  end

  // Selector write-enable trails the read by one cycle to line up with the
  // table data; the last literal's read turns into the all-ones select code.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_en <= '0;
    end else if (r_state == S_FETCH) begin
      r_wr_en <= (r_k == C_LAST) ? {NSAT_BITS{1'b1}} : (NSAT_BITS'(1) << r_k);
    end else begin
      r_wr_en <= '0;
    end
  end

  // Map the selector's choice back to a variable; out-of-range picks no literal.
  always_comb begin
    w_cap_var = '0;
    w_cap_hit = 1'b0;
    for (int i = 0; i < NSAT; i++) begin
      if (bus.selected_i == NSAT_BITS'(i)) begin
        w_cap_var = r_lits[i];
        w_cap_hit = 1'b1;
      end
    end
  end

  // Result registers: loaded once per job and frozen while waiting in OUT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_flip_var  <= '0;
      r_flip_idx  <= '0;
      r_flip_none <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_flip_var  <= w_cap_var;
      r_flip_idx  <= bus.selected_i;
      r_flip_none <= ~w_cap_hit | ~|r_mask;
    end
  end

  assign bus.ready_o              = w_ready;
  assign bus.var_rd_en_o          = w_rd_en;
  assign bus.var_addr_o           = w_rd_addr;
  assign bus.wr_en_o              = r_wr_en;
  assign bus.break_values_valid_o = r_mask;
  assign bus.random_o             = r_lfsr;
  assign bus.flip_valid_o         = w_flip_valid;
  assign bus.flip_var_o           = r_flip_var;
  assign bus.flip_idx_o           = r_flip_idx;
  assign bus.flip_none_o          = r_flip_none;

endmodule
`default_nettype wire

// File: tb/tb_flip_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_flip_select_sequencer
// Summary  : Self-checking bench for flip_select_sequencer with a job-timeline
//            reference model and randomized clause jobs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flip_select_sequencer;

  localparam int NSAT     = 3;
  localparam int VAR_BITS = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_en   = 1'b0;

  flip_select_sequencer_if #(.NSAT(NSAT), .VAR_BITS(VAR_BITS)) bus  ();
  flip_select_sequencer_if #(.NSAT(NSAT), .VAR_BITS(VAR_BITS)) bus0 ();

  flip_select_sequencer #(.NSAT(NSAT), .VAR_BITS(VAR_BITS), .SEED(32'hACE1_2468)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  flip_select_sequencer #(.NSAT(NSAT), .VAR_BITS(VAR_BITS), .SEED(32'h0)) u_dut_seed0 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus0.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // ---------------- reference model: job timeline ----------------
  // m_t is the cycle number relative to the accept edge (cycle 0).
  bit              m_busy;
  int              m_t;
  logic [15:0]     m_lits [NSAT];
  logic [NSAT-1:0] m_mask;
  logic [31:0]     m_rand;
  logic [15:0]     m_var;
  logic [1:0]      m_idx;
  logic            m_none;
  int              n_jobs = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_t    = 0;
      m_mask = '0;
      m_rand = 32'hACE1_2468;
      m_var  = '0;
      m_idx  = '0;
      m_none = 1'b0;
    end else if (!m_busy) begin
      if (bus.start_i) begin
        m_busy = 1'b1;
        m_t    = 1;
        for (int k = 0; k < NSAT; k++) m_lits[k] = bus.lits_i[k*VAR_BITS +: VAR_BITS];
        m_mask = bus.lit_valid_i;
        m_rand = lfsr_step(m_rand);
      end
    end else begin
      if (m_t == NSAT + 2) begin
        m_idx  = bus.selected_i;
        m_none = (int'(bus.selected_i) >= NSAT) || (m_mask == '0);
        m_var  = (int'(bus.selected_i) < NSAT) ? m_lits[bus.selected_i] : 16'h0;
      end
      if (m_t == NSAT + 3) begin
        if (bus.flip_ready_i) begin
          m_busy = 1'b0;
          n_jobs++;
        end
      end else begin
        m_t++;
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  logic        e_rd;
  logic [15:0] e_addr;
  logic [1:0]  e_wr;
  logic        e_valid;

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      e_rd    = m_busy && (m_t >= 1) && (m_t <= NSAT);
      e_addr  = e_rd ? m_lits[m_t-1] : 16'h0;
      if (m_busy && (m_t >= 2) && (m_t <= NSAT)) e_wr = 2'b01 << (m_t - 2);
      else if (m_busy && (m_t == NSAT + 1))      e_wr = 2'b11;
      else                                       e_wr = 2'b00;
      e_valid = m_busy && (m_t == NSAT + 3);
      chk("cmp_ready",  bus.ready_o, !m_busy);
      chk("cmp_rd_en",  bus.var_rd_en_o, e_rd);
      chk("cmp_addr",   bus.var_addr_o, e_addr);
      chk("cmp_wr_en",  bus.wr_en_o, e_wr);
      chk("cmp_bvv",    bus.break_values_valid_o, m_mask);
      chk("cmp_random", bus.random_o, m_rand);
      chk("cmp_valid",  bus.flip_valid_o, e_valid);
      if (e_valid) begin
        chk("cmp_flip_var",  bus.flip_var_o, m_var);
        chk("cmp_flip_idx",  bus.flip_idx_o, m_idx);
        chk("cmp_flip_none", bus.flip_none_o, m_none);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2,
                         input logic [2:0] mask, input logic [1:0] sel,
                         input logic [15:0] ev, input logic [1:0] ei, input logic en,
                         input logic [31:0] er);
    bus.lits_i       = {l2, l1, l0};
    bus.lit_valid_i  = mask;
    bus.selected_i   = sel;
    bus.flip_ready_i = 1'b1;
    bus.start_i      = 1'b1;
    for (int i = 0; i < 20 && !bus.ready_o; i++) step();
    chk("job_ready_before", bus.ready_o, 1'b1);
    step();                       // cycle 1
    bus.start_i = 1'b0;
    chk("job_rd1", bus.var_rd_en_o, 1'b1);
    chk("job_addr1", bus.var_addr_o, l0);
    chk("job_wr1", bus.wr_en_o, 2'b00);
    step();                       // cycle 2
    chk("job_addr2", bus.var_addr_o, l1);
    chk("job_wr2", bus.wr_en_o, 2'b01);
    step();                       // cycle 3
    chk("job_addr3", bus.var_addr_o, l2);
    chk("job_wr3", bus.wr_en_o, 2'b10);
    step();                       // cycle 4
    chk("job_rd4", bus.var_rd_en_o, 1'b0);
    chk("job_wr4", bus.wr_en_o, 2'b11);
    step();                       // cycle 5
    chk("job_valid5", bus.flip_valid_o, 1'b0);
    chk("job_wr5", bus.wr_en_o, 2'b00);
    step();                       // cycle 6
    chk("job_valid6", bus.flip_valid_o, 1'b1);
    chk("job_flip_var", bus.flip_var_o, ev);
    chk("job_flip_idx", bus.flip_idx_o, ei);
    chk("job_flip_none", bus.flip_none_o, en);
    chk("job_random", bus.random_o, er);
    chk("job_bvv", bus.break_values_valid_o, mask);
    step();                       // cycle 7
    chk("job_ready_after", bus.ready_o, 1'b1);
    chk("job_valid7", bus.flip_valid_o, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.start_i       = 1'b0;
    bus.lits_i        = '0;
    bus.lit_valid_i   = '0;
    bus.selected_i    = '0;
    bus.flip_ready_i  = 1'b0;
    bus0.start_i      = 1'b0;
    bus0.lits_i       = '0;
    bus0.lit_valid_i  = '0;
    bus0.selected_i   = '0;
    bus0.flip_ready_i = 1'b0;

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    cmp_en = 1'b1;

    // reset / idle values
    chk("rst_random", bus.random_o, 32'hACE1_2468);
    chk("rst_ready", bus.ready_o, 1'b1);
    chk("rst_wr_en", bus.wr_en_o, 2'b00);
    chk("rst_valid", bus.flip_valid_o, 1'b0);
    chk("seed0_random", bus0.random_o, 32'h1);

    // directed job {5,9,12}, selector picks literal 1
    run_job(16'd5, 16'd9, 16'd12, 3'b111, 2'd1, 16'd9, 2'd1, 1'b0, 32'h5670_9234);

    // backpressure: flip_ready low for 4 cycles with stray start pulses
    bus.lits_i       = {16'd300, 16'd200, 16'd100};
    bus.lit_valid_i  = 3'b101;
    bus.selected_i   = 2'd2;
    bus.flip_ready_i = 1'b0;
    bus.start_i      = 1'b1;
    step();                       // cycle 1
    bus.start_i = 1'b0;
    repeat (5) step();            // cycle 6
    chk("bp_valid", bus.flip_valid_o, 1'b1);
    chk("bp_var", bus.flip_var_o, 16'd300);
    chk("bp_random", bus.random_o, 32'h2B38_491A);
    for (int i = 0; i < 4; i++) begin
      bus.start_i = 1'b1;
      step();
      chk("bp_hold_valid", bus.flip_valid_o, 1'b1);
      chk("bp_hold_var", bus.flip_var_o, 16'd300);
      chk("bp_hold_ready", bus.ready_o, 1'b0);
      chk("bp_hold_wr", bus.wr_en_o, 2'b00);
    end
    bus.start_i      = 1'b0;
    bus.flip_ready_i = 1'b1;
    step();
    chk("bp_release_ready", bus.ready_o, 1'b1);
    chk("bp_release_random", bus.random_o, 32'h2B38_491A);

    // empty mask: no legal choice
    run_job(16'd7, 16'd8, 16'd9, 3'b000, 2'd0, 16'd7, 2'd0, 1'b1, 32'h159C_248D);
    // out-of-range selection
    run_job(16'd21, 16'd22, 16'd23, 3'b111, 2'd3, 16'd0, 2'd3, 1'b1, 32'h8AEE_1245);

    // asynchronous reset in the third FETCH cycle
    bus.lits_i      = {16'd3, 16'd2, 16'd1};
    bus.lit_valid_i = 3'b111;
    bus.start_i     = 1'b1;
    step();                       // cycle 1
    bus.start_i = 1'b0;
    step();
    step();                       // cycle 3
    chk("ar_rd_before", bus.var_rd_en_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ready", bus.ready_o, 1'b1);
    chk("ar_rd_en", bus.var_rd_en_o, 1'b0);
    chk("ar_addr", bus.var_addr_o, 16'd0);
    chk("ar_wr_en", bus.wr_en_o, 2'b00);
    chk("ar_bvv", bus.break_values_valid_o, 3'b000);
    chk("ar_valid", bus.flip_valid_o, 1'b0);
    chk("ar_flip_var", bus.flip_var_o, 16'd0);
    chk("ar_flip_idx", bus.flip_idx_o, 2'd0);
    chk("ar_flip_none", bus.flip_none_o, 1'b0);
    chk("ar_random", bus.random_o, 32'hACE1_2468);
    step();
    rst_n = 1'b1;
    step();
    run_job(16'd5, 16'd9, 16'd12, 3'b111, 2'd1, 16'd9, 2'd1, 1'b0, 32'h5670_9234);

    // randomized traffic, including back-to-back starts and occasional resets
    for (int c = 0; c < 1500; c++) begin
      bus.start_i      = ($urandom_range(0, 3) != 0);
      bus.lits_i       = {16'($urandom), 16'($urandom), 16'($urandom)};
      bus.lit_valid_i  = 3'($urandom_range(0, 7));
      bus.selected_i   = 2'($urandom_range(0, 3));
      bus.flip_ready_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    chk("random_jobs_completed", (n_jobs >= 20), 1'b1);
    chk("seed0_random_idle", bus0.random_o, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flip_select_sequencer.md
# flip_select_sequencer

Control stage directly upstream of the variable flip selector. It accepts one unsatisfied clause (NSAT literal variable indices), reads each literal's clause-occupancy row from the variable-clause table, and drives the selector's write-enable encoding. It then triggers heuristic selection and returns the chosen variable to the flip unit over a valid/ready handshake. It also owns the 32-bit LFSR that supplies the selector's random input.

## Interface
- NSAT, 3, literals per clause (≥2); NSAT_BITS = $clog2(NSAT)
- VAR_BITS, 16, variable index width
- SEED, 32'hACE1_2468, LFSR reset value; 0 is illegal and maps to 32'h1
- clk_i  in  1  single clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  clause job valid
- ready_o  out  1  high iff state IDLE
- lits_i  in  NSAT*VAR_BITS  literal k variable at [k*VAR_BITS +: VAR_BITS]
- lit_valid_i  in  NSAT  per-literal present mask
- var_rd_en_o  out  1  table read strobe; data returns 1 cycle later directly to selector
- var_addr_o  out  VAR_BITS  table read address
- wr_en_o  out  NSAT_BITS  selector control: 0 idle, one-hot bit k = latch literal k, all-ones = select
- break_values_valid_o  out  NSAT  captured lit_valid_i, held for the job
- random_o  out  32  LFSR state
- selected_i  in  NSAT_BITS  selector's registered choice
- flip_valid_o  out  1  result valid
- flip_ready_i  in  1  flip unit ready
- flip_var_o  out  VAR_BITS  variable to flip
- flip_idx_o  out  NSAT_BITS  literal position chosen
- flip_none_o  out  1  no legal choice (no valid literals or selected_i ≥ NSAT)

## Operation
- States: IDLE, FETCH, SELECT, CAPTURE, OUT.
- IDLE: on start_i (ready_o=1) register lits_i, lit_valid_i (to break_values_valid_o), k←0, advance LFSR once; → FETCH.
- FETCH (NSAT cycles): var_rd_en_o=1, var_addr_o=lit[k], k increments; after k=NSAT-1 → SELECT.
- wr_en_o is registered from previous cycle's read: read of literal k<NSAT-1 produces wr_en_o = 1<<k next cycle; read of literal NSAT-1 produces wr_en_o = all-ones (the SELECT cycle). Otherwise wr_en_o=0.
- SELECT: one cycle, wr_en_o all-ones, var_rd_en_o=0; → CAPTURE.
- CAPTURE: sample selected_i; flip_idx_o←selected_i; flip_var_o←lit[selected_i] if selected_i<NSAT else 0; flip_none_o←(selected_i≥NSAT) | ~|lit_valid; → OUT.
- OUT: flip_valid_o=1, outputs stable until flip_ready_i; on handshake → IDLE.
- LFSR: Galois, lfsr ← (lfsr>>1) ^ (lfsr[0] ? 32'h80200003 : 0), advances only on job accept, so random_o is constant throughout a job.
- Reset (any time, incl. mid-job): state IDLE, ready_o=1, var_rd_en_o=0, var_addr_o=0, wr_en_o=0, break_values_valid_o=0, flip_valid_o=0, flip_var_o=0, flip_idx_o=0, flip_none_o=0, random_o=SEED (or 1). No partial job survives.

## Timing
- Accept at cycle 0. Reads in cycles 1..NSAT. wr_en_o one-hot in cycles 2..NSAT. All-ones in cycle NSAT+1. selected_i sampled in cycle NSAT+2. flip_valid_o high from cycle NSAT+3.
- NSAT=3: reads 1-3, wr_en 01@2, 10@3, 11@4, capture @5, flip_valid @6.
- start_i ignored outside IDLE. Next job is accepted earliest the cycle after the OUT handshake; no overlap.
- flip_ready_i held low: OUT persists indefinitely, all outputs frozen, wr_en_o=0.
- Only wr_en_o one-hot or all-ones values listed above ever appear; never a non-one-hot partial pattern.

## Test plan
- Reset then idle: random_o=32'hACE12468, ready_o=1, wr_en_o=0, flip_valid_o=0. SEED=0 build gives random_o=1.
- NSAT=3 job lits {5,9,12}, mask 111, flip_ready_i=1, selected_i=01 at cycle 5 → addr 5,9,12 on cycles 1-3; wr_en 01,10,11 on 2-4; flip_valid cycle 6 with flip_var_o=9, flip_idx_o=1, flip_none_o=0; random_o = one LFSR step from SEED.
- Backpressure: flip_ready_i low 4 cycles → flip_valid_o held, flip_var_o stable, start_i pulses ignored; accept only after handshake.
- mask 000 → break_values_valid_o=000, flip_none_o=1. Separately, selected_i=11 with mask 111 → flip_none_o=1, flip_var_o=0.
- rst_ni dropped asynchronously during cycle 3 of FETCH → outputs go to reset values immediately. After release, a new job runs with full correct latency.
- Back-to-back jobs: random_o differs by exactly one LFSR step per job; no wr_en_o glitch between jobs.
